// File: rtl/nest_setup_ctrl.sv
// ============================================================================
// nest_setup_ctrl : draws PRNG coordinates, places the nest, then FOOD_COUNT food sources
// Revision: 1.0
// ============================================================================
`default_nettype none

module nest_setup_ctrl #(
    parameter int FOOD_COUNT  = 4,
    parameter int MAX_RETRY   = 15,
    parameter int EDGE_MARGIN = 8,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_BITS      = 10,
    parameter int Y_BITS      = 9
) (
    input  logic                  Clk,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [X_BITS-1:0]     rand_x,
    input  logic [Y_BITS-1:0]     rand_y,
    output logic                  rand_next,
    output logic                  setup_phase,
    output logic [X_BITS-1:0]     place_x,
    output logic [Y_BITS-1:0]     place_y,
    input  logic                  nest_collision,
    output logic                  nest_set,
    output logic [FOOD_COUNT-1:0] food_set,
    output logic                  done,
    output logic                  fail,
    output logic [7:0]            retries
);

    localparam logic [X_BITS-1:0] X_LO        = X_BITS'(EDGE_MARGIN);
    localparam logic [X_BITS-1:0] X_HI        = X_BITS'(X_MAX - EDGE_MARGIN);
    localparam logic [Y_BITS-1:0] Y_LO        = Y_BITS'(EDGE_MARGIN);
    localparam logic [Y_BITS-1:0] Y_HI        = Y_BITS'(Y_MAX - EDGE_MARGIN);
    localparam logic [3:0]        LAST_IDX    = 4'(FOOD_COUNT - 1);
    localparam logic [7:0]        RETRY_LIMIT = 8'(MAX_RETRY);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_NEST_DRAW  = 3'd1;
    localparam logic [2:0] S_NEST_CHECK = 3'd2;
    localparam logic [2:0] S_FOOD_DRAW  = 3'd3;
    localparam logic [2:0] S_FOOD_CHECK = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_FAIL       = 3'd6;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] idx;
    logic       in_bounds;
    logic       food_ok;
    logic       retry_exhausted;
    logic       is_draw;
    logic       restart;
    logic [7:0] retries_inc;

    assign in_bounds = (place_x >= X_LO) && (place_x <= X_HI) &&
                       (place_y >= Y_LO) && (place_y <= Y_HI);
    assign food_ok         = in_bounds && !nest_collision;
    assign retries_inc     = retries + 8'd1;
    assign retry_exhausted = (retries_inc == RETRY_LIMIT);
    assign is_draw         = (state == S_NEST_DRAW) || (state == S_FOOD_DRAW);
    assign restart         = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (start) next_state = S_NEST_DRAW;
            S_NEST_DRAW:  next_state = S_NEST_CHECK;
            S_NEST_CHECK: begin
                if (in_bounds)            next_state = S_FOOD_DRAW;
                else if (retry_exhausted) next_state = S_FAIL;
                else                      next_state = S_NEST_DRAW;
            end
            S_FOOD_DRAW:  next_state = S_FOOD_CHECK;
            S_FOOD_CHECK: begin
                if (food_ok)              next_state = (idx == LAST_IDX) ? S_DONE : S_FOOD_DRAW;
                else if (retry_exhausted) next_state = S_FAIL;
                else                      next_state = S_FOOD_DRAW;
            end
            S_DONE, S_FAIL: if (start) next_state = S_NEST_DRAW;
            default:      next_state = S_IDLE;
        endcase
    end

    // Strobes are decoded in the check cycle so the object latches on the edge that ends it.
    always_comb begin
        nest_set = (state == S_NEST_CHECK) && in_bounds;
        food_set = '0;
        for (int i = 0; i < FOOD_COUNT; i++) begin
            food_set[i] = (state == S_FOOD_CHECK) && food_ok && (idx == 4'(i));
        end
    end

    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            rand_next   <= 1'b0;
            setup_phase <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            place_x     <= '0;
            place_y     <= '0;
            retries     <= '0;
            idx         <= '0;
        end else begin
            rand_next   <= is_draw;
            setup_phase <= (next_state == S_NEST_DRAW)  || (next_state == S_NEST_CHECK) ||
                           (next_state == S_FOOD_DRAW)  || (next_state == S_FOOD_CHECK);
            done        <= (next_state == S_DONE);
            fail        <= (next_state == S_FAIL);
            if (is_draw) begin
                place_x <= rand_x;
                place_y <= rand_y;
            end
            if (restart) begin
                retries <= '0;
                idx     <= '0;
            end else if (state == S_NEST_CHECK) begin
                retries <= in_bounds ? 8'd0 : retries_inc;
            end else if (state == S_FOOD_CHECK) begin
                if (food_ok) begin
                    retries <= '0;
                    if (idx != LAST_IDX) idx <= idx + 4'd1;
                end else begin
                    retries <= retries_inc;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nest_setup_ctrl.sv
// ============================================================================
// tb_nest_setup_ctrl : directed placement scenarios checked against a draw-list model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nest_setup_ctrl;

    localparam int FC   = 4;
    localparam int MR   = 3;
    localparam int EM   = 8;
    localparam int XMAX = 639;
    localparam int YMAX = 479;
    localparam int XB   = 10;
    localparam int YB   = 9;

    logic           Clk = 1'b0;
    logic           RESET_N = 1'b0;
    logic           start = 1'b0;
    logic [XB-1:0]  rand_x;
    logic [YB-1:0]  rand_y;
    logic           rand_next, setup_phase, nest_set, done, fail, nest_collision;
    logic [XB-1:0]  place_x;
    logic [YB-1:0]  place_y;
    logic [FC-1:0]  food_set;
    logic [7:0]     retries;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    nest_setup_ctrl #(
        .FOOD_COUNT(FC), .MAX_RETRY(MR), .EDGE_MARGIN(EM),
        .X_MAX(XMAX), .Y_MAX(YMAX), .X_BITS(XB), .Y_BITS(YB)
    ) dut (
        .Clk(Clk), .RESET_N(RESET_N), .start(start),
        .rand_x(rand_x), .rand_y(rand_y), .rand_next(rand_next),
        .setup_phase(setup_phase), .place_x(place_x), .place_y(place_y),
        .nest_collision(nest_collision), .nest_set(nest_set), .food_set(food_set),
        .done(done), .fail(fail), .retries(retries)
    );

    // PRNG stand-in: replays a table, advancing once per rand_next pulse
    int tbl_x [0:15];
    int tbl_y [0:15];
    int tlen = 0;
    int pptr = 0;
    int base = 0;
    int rk;

    always @(posedge Clk) if (rand_next) pptr <= pptr + 1;

    always_comb begin
        rk     = pptr - base;
        rand_x = '0;
        rand_y = '0;
        if (rk >= 0 && rk < tlen) begin
            rand_x = XB'(tbl_x[rk]);
            rand_y = YB'(tbl_y[rk]);
        end
    end

    // Nest object stand-in
    logic          nest_valid;
    logic [XB-1:0] nest_x;
    logic [YB-1:0] nest_y;

    always @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            nest_valid <= 1'b0;
            nest_x     <= '0;
            nest_y     <= '0;
        end else if (nest_set) begin
            nest_valid <= 1'b1;
            nest_x     <= place_x;
            nest_y     <= place_y;
        end
    end

    assign nest_collision = nest_valid && (place_x == nest_x) && (place_y == nest_y);

    // Expected-output model: a per-cycle list derived from the draw table
    typedef struct {
        logic          sp, rn, ns, dn, fl;
        logic [FC-1:0] fs;
        int            px, py, rt;
    } rec_t;

    rec_t q[$];
    rec_t hold, zero_rec, ce;
    int   m_px = 0;
    int   m_py = 0;
    bit   armed = 0;

    function automatic rec_t mk(input logic sp, input logic rn, input int px, input int py,
                                input logic ns, input logic [FC-1:0] fs,
                                input logic dn, input logic fl, input int rt);
        rec_t r;
        r.sp = sp; r.rn = rn; r.px = px; r.py = py; r.ns = ns;
        r.fs = fs; r.dn = dn; r.fl = fl; r.rt = rt;
        return r;
    endfunction

    task automatic plan();
        int p = 0;
        int r = 0;
        int nx = 0, ny = 0, cx, cy;
        bit nv = 0;
        bit placed, legal;
        logic [FC-1:0] fs;
        for (int obj = 0; obj <= FC; obj++) begin
            placed = 0;
            while (!placed) begin
                q.push_back(mk(1, 0, m_px, m_py, 0, '0, 0, 0, r));
                cx = (p < tlen) ? tbl_x[p] : 0;
                cy = (p < tlen) ? tbl_y[p] : 0;
                p++;
                m_px = cx;
                m_py = cy;
                legal = (cx >= EM) && (cx <= XMAX - EM) && (cy >= EM) && (cy <= YMAX - EM) &&
                        !(obj > 0 && nv && cx == nx && cy == ny);
                fs = '0;
                if (legal && obj > 0) fs[obj-1] = 1'b1;
                q.push_back(mk(1, 1, cx, cy, legal && obj == 0, fs, 0, 0, r));
                if (legal) begin
                    placed = 1;
                    r = 0;
                    if (obj == 0) begin nx = cx; ny = cy; nv = 1; end
                end else begin
                    r++;
                    if (r == MR) begin
                        q.push_back(mk(0, 0, m_px, m_py, 0, '0, 0, 1, r));
                        return;
                    end
                end
            end
        end
        q.push_back(mk(0, 0, m_px, m_py, 0, '0, 1, 0, 0));
    endtask

    always @(negedge Clk) begin
        if (armed) begin
            if (q.size() > 0) begin
                ce   = q.pop_front();
                hold = ce;
            end else begin
                ce = hold;
            end
            vectors++;
            if (setup_phase !== ce.sp || rand_next !== ce.rn || place_x !== XB'(ce.px) ||
                place_y !== YB'(ce.py) || nest_set !== ce.ns || food_set !== ce.fs ||
                done !== ce.dn || fail !== ce.fl || retries !== 8'(ce.rt)) begin
                miscompares++;
                $display("FAIL cycle t=%0t got sp=%b rn=%b xy=(%0d,%0d) ns=%b fs=%b dn=%b fl=%b rt=%0d, want sp=%b rn=%b xy=(%0d,%0d) ns=%b fs=%b dn=%b fl=%b rt=%0d",
                         $time, setup_phase, rand_next, place_x, place_y, nest_set, food_set, done, fail, retries,
                         ce.sp, ce.rn, ce.px, ce.py, ce.ns, ce.fs, ce.dn, ce.fl, ce.rt);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic put(input int x, input int y);
        tbl_x[tlen] = x;
        tbl_y[tlen] = y;
        tlen++;
    endtask

    task automatic load_basic();
        tlen = 0;
        put(100, 100); put(300, 200); put(400, 50); put(50, 400); put(600, 300);
    endtask

    // Pulse start for one edge and queue the expected trace; returns in cycle 1
    task automatic kick();
        @(negedge Clk); #1;
        base  = pptr;
        start = 1'b1;
        plan();
        @(negedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic step();
        @(negedge Clk); #1;
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        while (!(done || fail) && n < 60) begin
            step();
            n++;
        end
        chk({nm, " finished"}, int'(done || fail), 1);
        step();
    endtask

    int nest_cyc, done_cyc, fail_cyc, strobe_seen;
    int fcyc [0:FC-1];

    initial begin
        zero_rec = mk(0, 0, 0, 0, 0, '0, 0, 0, 0);
        hold     = zero_rec;
        armed    = 1;
        repeat (3) @(negedge Clk);
        #1 RESET_N = 1'b1;
        step();
        chk("reset setup_phase", int'(setup_phase), 0);
        chk("reset place_x", int'(place_x), 0);
        chk("reset retries", int'(retries), 0);

        // Clean run, zero retries
        load_basic();
        kick();
        nest_cyc = -1; done_cyc = -1;
        for (int i = 0; i < FC; i++) fcyc[i] = -1;
        for (int c = 1; c <= 12; c++) begin
            if (nest_set && nest_cyc < 0) nest_cyc = c;
            for (int i = 0; i < FC; i++) if (food_set[i] && fcyc[i] < 0) fcyc[i] = c;
            if (done && done_cyc < 0) done_cyc = c;
            step();
        end
        chk("clean nest_set cycle", nest_cyc, 2);
        chk("clean food0 cycle", fcyc[0], 4);
        chk("clean food1 cycle", fcyc[1], 6);
        chk("clean food2 cycle", fcyc[2], 8);
        chk("clean food3 cycle", fcyc[3], 10);
        chk("clean done cycle", done_cyc, 11);

        // Two nest rejections, restart from DONE
        tlen = 0;
        put(3, 100); put(100, 475); put(120, 120);
        put(300, 200); put(400, 50); put(50, 400); put(600, 300);
        kick();
        for (int c = 1; c < 5; c++) step();
        chk("nest retry count", int'(retries), 2);
        step();
        chk("nest_set after retries", int'(nest_set), 1);
        chk("nest place_x", int'(place_x), 120);
        chk("nest place_y", int'(place_y), 120);
        wait_end("retry run");

        // Food candidate on the nest collides
        tlen = 0;
        put(100, 100); put(100, 100); put(200, 200);
        put(300, 200); put(400, 50); put(50, 400);
        kick();
        for (int c = 1; c < 4; c++) step();
        chk("collision seen", int'(nest_collision), 1);
        chk("collision food_set", int'(food_set), 0);
        step();
        chk("collision retries", int'(retries), 1);
        step();
        chk("food0 after collision", int'(food_set), 1);
        wait_end("collision run");

        // Edge-margin boundaries
        tlen = 0;
        put(7, 100); put(632, 100); put(8, 100);
        put(631, 200); put(300, 8); put(400, 471); put(50, 50);
        kick();
        for (int c = 1; c < 6; c++) step();
        chk("x=8 nest_set", int'(nest_set), 1);
        step(); step();
        chk("x=631 food_set", int'(food_set), 1);
        wait_end("boundary run");

        // Retry budget exhausted
        tlen = 0;
        put(0, 0); put(700, 10); put(5, 5);
        kick();
        fail_cyc = -1; strobe_seen = 0;
        for (int c = 1; c <= 9; c++) begin
            if (nest_set || food_set != 0) strobe_seen = 1;
            if (fail && fail_cyc < 0) begin
                fail_cyc = c;
                chk("fail setup_phase", int'(setup_phase), 0);
            end
            step();
        end
        chk("fail cycle", fail_cyc, 7);
        chk("fail no strobe", strobe_seen, 0);
        load_basic();
        kick();
        chk("restart clears fail", int'(fail), 0);
        wait_end("restart after fail");

        // Asynchronous reset during FOOD_CHECK
        load_basic();
        kick();
        for (int c = 1; c < 4; c++) step();
        chk("pre-reset food_set", int'(food_set), 1);
        #2 RESET_N = 1'b0;
        q.delete();
        hold = zero_rec;
        m_px = 0;
        m_py = 0;
        #1;
        chk("async reset outputs", int'({setup_phase, rand_next, nest_set, food_set, done, fail}), 0);
        chk("async reset place", int'(place_x) + int'(place_y) + int'(retries), 0);
        step();
        RESET_N = 1'b1;
        step();
        load_basic();
        kick();
        wait_end("rerun after reset");
        chk("rerun done", int'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
